// File: rtl/ipsxe_floating_point_pkg_v1_0.sv
// Shared constants and packed-word layout for the floating-point FMA path.
// Widths are passed in so the same helpers serve every precision.
package ipsxe_floating_point_pkg_v1_0;

    localparam int SP_EXP_WIDTH = 8;
    localparam int SP_MAN_WIDTH = 23;

    function automatic int fp_bias(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    // Binary point of the adder's magnitude sits between bits [fp_point] and [fp_point-1].
    function automatic int fp_point(input int man_width);
        return 2 * man_width;
    endfunction

    function automatic int fp_sum_width(input int man_width);
        return 2 * (man_width + 1) + 1;
    endfunction

    // {sign, exp[EXP_WIDTH:0], abs_sum[N-1:0]} as produced by the adder stage
    function automatic int add_exp_lsb(input int man_width);
        return fp_sum_width(man_width);
    endfunction

    function automatic int add_sign_bit(input int exp_width, input int man_width);
        return fp_sum_width(man_width) + exp_width + 1;
    endfunction

    localparam int          SP_BIAS     = fp_bias(SP_EXP_WIDTH);
    localparam int          SP_FP       = fp_point(SP_MAN_WIDTH);
    localparam int          SP_N        = fp_sum_width(SP_MAN_WIDTH);
    localparam logic [31:0] SP_POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] SP_NEG_INF  = 32'hFF80_0000;
    localparam logic [31:0] SP_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] SP_NEG_ZERO = 32'h8000_0000;

endpackage

// File: rtl/ipsxe_floating_point_lzc_v1_0.sv
// Leading-one position detector built as a binary tree over the input padded
// to a power of two; o_valid=0 means the input was all zeros.
module ipsxe_floating_point_lzc_v1_0 #(
    parameter int W = 49
) (
    input  logic [W-1:0]         i_data,
    output logic [$clog2(W)-1:0] o_pos,
    output logic                 o_valid
);

    localparam int L = $clog2(W);
    localparam int P = 1 << L;

    logic [P-1:0] din_pad;

    always_comb begin
        din_pad          = '0;
        din_pad[W-1:0]   = i_data;
    end

    // Level k has P>>k nodes, each covering 2^k bits with a k-bit position.
    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int NODES = P >> k;
        logic [NODES-1:0]   v;
        logic [NODES*k-1:0] pos;

        for (genvar i = 0; i < NODES; i++) begin : g_node
            if (k == 1) begin : g_leaf
                assign v[i]   = din_pad[2*i+1] | din_pad[2*i];
                assign pos[i] = din_pad[2*i+1];
            end else begin : g_merge
                assign v[i] = g_lvl[k-1].v[2*i+1] | g_lvl[k-1].v[2*i];
                assign pos[i*k +: k] = g_lvl[k-1].v[2*i+1]
                    ? {1'b1, g_lvl[k-1].pos[(2*i+1)*(k-1) +: (k-1)]}
                    : {1'b0, g_lvl[k-1].pos[(2*i)*(k-1) +: (k-1)]};
            end
        end
    end

    assign o_pos   = g_lvl[L].pos;
    assign o_valid = g_lvl[L].v[0];

endmodule

// File: rtl/ipsxe_floating_point_pipe_v1_0.sv
// Clock-enabled pipeline register with async clear; collapses to a wire when EN=0
// so the top can place a variable number of cuts.
module ipsxe_floating_point_pipe_v1_0 #(
    parameter int W  = 1,
    parameter bit EN = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_aclken,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    if (EN) begin : g_reg
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                o_q <= '0;
            end else if (i_aclken) begin
                o_q <= i_d;
            end
        end
    end else begin : g_wire
        logic unused_ctl;
        assign unused_ctl = i_clk ^ i_rst_n ^ i_aclken;
        assign o_q = i_d;
    end

endmodule

// File: rtl/ipsxe_floating_point_norm_round_single_v1_0.sv
// FMA back end: normalise the adder's magnitude, round to nearest-even and pack
// an IEEE word. Register cuts: after leading-one detect, after round, at output.
module ipsxe_floating_point_norm_round_single_v1_0
    import ipsxe_floating_point_pkg_v1_0::*;
#(
    parameter int EXP_WIDTH   = 8,
    parameter int MAN_WIDTH   = 23,
    parameter int PIPE_STAGES = 3,
    parameter int W_USER      = 1
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst_n,
    input  logic                                          i_aclken,
    input  logic                                          i_valid,
    input  logic [2*(MAN_WIDTH+1)+1+EXP_WIDTH+1:0]        i_add_out,
    input  logic                                          i_special,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]                  i_special_value,
    input  logic [W_USER-1:0]                             i_user,
    output logic                                          o_valid,
    output logic [EXP_WIDTH+MAN_WIDTH:0]                  o_result,
    output logic                                          o_overflow,
    output logic                                          o_underflow,
    output logic                                          o_inexact,
    output logic [W_USER-1:0]                             o_user
);

    localparam int BIAS     = fp_bias(EXP_WIDTH);
    localparam int FP       = fp_point(MAN_WIDTH);
    localparam int N        = fp_sum_width(MAN_WIDTH);
    localparam int PW       = $clog2(N);
    localparam int EBW      = EXP_WIDTH + 3;
    localparam int RW       = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int EXP_LSB  = add_exp_lsb(MAN_WIDTH);
    localparam int SIGN_BIT = add_sign_bit(EXP_WIDTH, MAN_WIDTH);

    localparam logic signed [EBW-1:0] EB_MAX  = EBW'((1 << EXP_WIDTH) - 1);
    localparam logic signed [EBW-1:0] EB_ZERO = '0;
    localparam logic [EBW-1:0]        EB_OFFS = EBW'(BIAS + FP);

    // ---------------- stage 1: leading-one detect ----------------
    logic                   in_sign;
    logic [EXP_WIDTH:0]     in_exp;
    logic [N-1:0]           in_abs;
    logic [PW-1:0]          c1_pos;
    logic                   c1_nz;
    logic signed [EBW-1:0]  c1_eb;

    assign in_sign = i_add_out[SIGN_BIT];
    assign in_exp  = i_add_out[EXP_LSB +: EXP_WIDTH+1];
    assign in_abs  = i_add_out[N-1:0];

    ipsxe_floating_point_lzc_v1_0 #(.W(N)) u_lzc (
        .i_data  (in_abs),
        .o_pos   (c1_pos),
        .o_valid (c1_nz)
    );

    assign c1_eb = EBW'(in_exp) + EBW'(c1_pos) - EB_OFFS;

    localparam int S1W = 1 + W_USER + 1 + RW + 1 + 1 + N + PW + EBW;

    logic [S1W-1:0]         s1_d, s1_q;
    logic                   s1_valid, s1_special, s1_sign, s1_zero;
    logic [W_USER-1:0]      s1_user;
    logic [RW-1:0]          s1_sval;
    logic [N-1:0]           s1_abs;
    logic [PW-1:0]          s1_pos;
    logic signed [EBW-1:0]  s1_eb;

    assign s1_d = {i_valid, i_user, i_special, i_special_value, in_sign, ~c1_nz,
                   in_abs, c1_pos, c1_eb};

    ipsxe_floating_point_pipe_v1_0 #(.W(S1W), .EN(PIPE_STAGES >= 3)) u_pipe_s1 (
        .i_clk (i_clk), .i_rst_n (i_rst_n), .i_aclken (i_aclken),
        .i_d   (s1_d),  .o_q     (s1_q)
    );

    assign {s1_valid, s1_user, s1_special, s1_sval, s1_sign, s1_zero,
            s1_abs, s1_pos, s1_eb} = s1_q;

    // ---------------- stage 2: shift + round ----------------
    logic [PW-1:0]          c2_shamt;
    logic [N-1:0]           c2_sh;
    logic [MAN_WIDTH-1:0]   c2_man;
    logic                   c2_guard, c2_sticky, c2_rnd;
    logic [MAN_WIDTH:0]     c2_man_r;
    logic signed [EBW-1:0]  c2_er;
    logic                   c2_ovf, c2_unf;
    logic                   unused_lead;

    assign c2_shamt  = PW'(N - 1) - s1_pos;
    assign c2_sh     = s1_abs << c2_shamt;
    assign unused_lead = c2_sh[N-1];
    assign c2_man    = c2_sh[N-2 -: MAN_WIDTH];
    assign c2_guard  = c2_sh[N-2-MAN_WIDTH];
    assign c2_sticky = |c2_sh[N-3-MAN_WIDTH:0];
    assign c2_rnd    = c2_guard & (c2_sticky | c2_man[0]);
    // A carry out of the mantissa leaves the low bits at zero, which is exactly 1.0 x 2.
    assign c2_man_r  = {1'b0, c2_man} + {{MAN_WIDTH{1'b0}}, c2_rnd};
    assign c2_er     = s1_eb + {{(EBW-1){1'b0}}, c2_man_r[MAN_WIDTH]};
    assign c2_ovf    = (c2_er >= EB_MAX);
    assign c2_unf    = (s1_eb <= EB_ZERO);

    localparam int S2W = 1 + W_USER + 1 + RW + 1 + 1 + 1 + 1 + EXP_WIDTH + MAN_WIDTH + 1;

    logic [S2W-1:0]         s2_d, s2_q;
    logic                   s2_valid, s2_special, s2_sign, s2_zero, s2_ovf, s2_unf, s2_gs;
    logic [W_USER-1:0]      s2_user;
    logic [RW-1:0]          s2_sval;
    logic [EXP_WIDTH-1:0]   s2_exp;
    logic [MAN_WIDTH-1:0]   s2_man;

    assign s2_d = {s1_valid, s1_user, s1_special, s1_sval, s1_sign, s1_zero, c2_ovf, c2_unf,
                   c2_er[EXP_WIDTH-1:0], c2_man_r[MAN_WIDTH-1:0], c2_guard | c2_sticky};

    ipsxe_floating_point_pipe_v1_0 #(.W(S2W), .EN(PIPE_STAGES >= 2)) u_pipe_s2 (
        .i_clk (i_clk), .i_rst_n (i_rst_n), .i_aclken (i_aclken),
        .i_d   (s2_d),  .o_q     (s2_q)
    );

    assign {s2_valid, s2_user, s2_special, s2_sval, s2_sign, s2_zero, s2_ovf, s2_unf,
            s2_exp, s2_man, s2_gs} = s2_q;

    // ---------------- stage 3: pack ----------------
    logic [RW-1:0] c3_res;
    logic          c3_ovf, c3_unf, c3_inex;

    always_comb begin
        c3_res  = {s2_sign, s2_exp, s2_man};
        c3_ovf  = 1'b0;
        c3_unf  = 1'b0;
        c3_inex = s2_gs;
        if (s2_special) begin
            c3_res  = s2_sval;
            c3_inex = 1'b0;
        end else if (s2_zero) begin
            c3_res  = '0;
            c3_inex = 1'b0;
        end else if (s2_ovf) begin
            c3_res  = {s2_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
            c3_ovf  = 1'b1;
            c3_inex = 1'b1;
        end else if (s2_unf) begin
            c3_res  = {s2_sign, {(RW-1){1'b0}}};
            c3_unf  = 1'b1;
            c3_inex = 1'b1;
        end
    end

    localparam int S3W = 1 + W_USER + RW + 3;

    logic [S3W-1:0] s3_d, s3_q;

    assign s3_d = {s2_valid, s2_user, c3_res, c3_ovf, c3_unf, c3_inex};

    ipsxe_floating_point_pipe_v1_0 #(.W(S3W), .EN(PIPE_STAGES >= 1)) u_pipe_s3 (
        .i_clk (i_clk), .i_rst_n (i_rst_n), .i_aclken (i_aclken),
        .i_d   (s3_d),  .o_q     (s3_q)
    );

    assign {o_valid, o_user, o_result, o_overflow, o_underflow, o_inexact} = s3_q;

endmodule

// File: doc/ipsxe_floating_point_norm_round_single_v1_0.md
Name: ipsxe_floating_point_norm_round_single_v1_0

Overview:
- Final stage of the single-precision fused multiply-add path. It sits directly downstream of the FMA adder stage.
- Consumes the unnormalised signed-magnitude sum word: sign, double-biased exponent and (2*(MAN_WIDTH+1)+1)-bit magnitude with the binary point between bits [2*MAN_WIDTH] and [2*MAN_WIDTH-1].
- Normalises the magnitude via leading-one detection, rounds to nearest-even and packs an IEEE-754 result.
- NaN/Inf results computed upstream bypass the datapath with matched latency.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- MAN_WIDTH, 23, stored mantissa width.
- PIPE_STAGES, 3, number of register cuts, legal 0..3. Cuts sit after leading-one detection, after shift+round, and at the output.
- W_USER, 1, sideband width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_aclken  in  1  clock enable for every pipeline register
- i_valid  in  1  input word valid
- i_add_out  in  (2*(MAN_WIDTH+1)+1)+(EXP_WIDTH+1)+1  packed as {sign, exp[EXP_WIDTH:0], abs_sum[2*(MAN_WIDTH+1):0]}
- i_special  in  1  upstream NaN/Inf/invalid detected; overrides datapath
- i_special_value  in  1+EXP_WIDTH+MAN_WIDTH  IEEE word to emit when i_special=1
- i_user  in  W_USER  sideband
- o_valid  out  1  result valid
- o_result  out  1+EXP_WIDTH+MAN_WIDTH  IEEE result
- o_overflow  out  1  result rounded to infinity
- o_underflow  out  1  result flushed to zero
- o_inexact  out  1  guard or sticky bit was nonzero
- o_user  out  W_USER  delayed i_user

Behaviour:
- Reset: i_clk and i_rst_n are the only clock and reset. Reset is asynchronous, active-low. While i_rst_n=0, all pipeline registers clear; o_valid, o_result, flags and o_user read 0. Deassertion mid-stream discards every in-flight word.
- Clock enable: i_aclken=0 holds all registers, valid included. Latency is PIPE_STAGES enabled cycles; PIPE_STAGES=0 is purely combinational. One result per enabled cycle, no backpressure.
- Constants: BIAS=2^(EXP_WIDTH-1)-1; FP=2*MAN_WIDTH (binary-point position); N=2*(MAN_WIDTH+1)+1.
- Value represented by the input: (-1)^sign * abs_sum * 2^-FP * 2^(exp-2*BIAS).
- Stage 1 (leading-one detection): p = index of the leading one in abs_sum, range 0..N-1. Compute e_b = exp - BIAS + p - FP in a signed EXP_WIDTH+3-bit intermediate; no truncation is permitted.
- Stage 2 (shift + round):
  - Left-shift abs_sum by N-1-p so the leading one lands in bit N-1.
  - Mantissa m = next MAN_WIDTH bits; guard g = following bit; sticky s = OR of all remaining bits.
  - Round up iff g & (s | m[0]).
  - If m overflows on rounding, m=0 and e_b += 1.
- Packing priority, highest first:
  - i_special=1: emit i_special_value; all flags 0.
  - abs_sum==0: emit +0 (sign forced 0); flags 0.
  - e_b >= 2^EXP_WIDTH-1 after rounding: emit signed infinity; o_overflow=1, o_inexact=1.
  - e_b <= 0 before rounding: emit signed zero (subnormals are flushed); o_underflow=1, o_inexact=1.
  - Otherwise emit {sign, e_b[EXP_WIDTH-1:0], m}; o_inexact = g|s.
- o_valid and o_user are delayed alongside the data. Flags are meaningful only when o_valid=1 but are still driven deterministically at all times.

Decomposition:
- Shared package ipsxe_floating_point_pkg_v1_0 holds:
  - constants BIAS, FP and N derived from EXP_WIDTH/MAN_WIDTH;
  - localparams for the IEEE infinity and zero encodings;
  - the packed-input field offsets shared with the adder stage.
- One sub-module: ipsxe_floating_point_lzc_v1_0, a parameterised-width leading-one position detector (tree structure), used in stage 1.
- Pipeline registers use the codebase's shift-register wrapper with i_aclken.

Test Plan:
- Normal value: sign=0, exp=254, abs_sum=1<<46 -> o_result=0x3F800000, flags 0, o_valid exactly 3 enabled cycles later.
- Round to even:
  - abs_sum=(1<<46)|(1<<22), exp=254 -> 0x3F800000, o_inexact=1.
  - abs_sum=(1<<46)|(1<<23)|(1<<22) -> 0x3F800002.
  - abs_sum=(1<<47)-1, exp=254 -> rounding carry gives 0x40000000.
- Overflow and underflow:
  - exp=380, abs_sum=1<<48, sign=1 -> 0xFF800000, o_overflow=1.
  - exp=127, abs_sum=1<<46 -> 0x00000000, o_underflow=1.
- Zero and special:
  - abs_sum=0, sign=1 -> 0x00000000, flags 0.
  - i_special=1 with i_special_value=0x7FC00000 -> 0x7FC00000 regardless of datapath inputs.
- Stall and reset:
  - Toggle i_aclken low for 5 cycles mid-stream -> outputs held, no word lost or duplicated, o_user sequence preserved.
  - Assert i_rst_n=0 mid-stream -> o_valid=0 and o_result=0 immediately (asynchronous), no stale results after release.
